// File: rtl/simd_mem_initiator.sv
// Initiator for one main_mem per-bank port: takes a SIMD vector load/store,
// holds the bank request until ram_done, then returns a single response.
module simd_mem_initiator #(
    parameter int LANES   = 32,
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [LANES-1:0]    req_mask,
    input  logic [7:0]          req_wstrb,
    input  logic [LANES*AW-1:0] req_addr,
    input  logic [LANES*DW-1:0] req_wdata,
    output logic [LANES-1:0]    ram_en,
    output logic [7:0]          ram_we,
    output logic [7:0]          ram_wstrb,
    output logic [LANES*AW-1:0] ram_addr,
    output logic [LANES*DW-1:0] ram_wdata,
    input  logic [LANES*DW-1:0] ram_rdata,
    input  logic                ram_done,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [LANES-1:0]    rsp_mask,
    output logic [LANES*DW-1:0] rsp_rdata,
    output logic [1:0]          rsp_error
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic [LANES-1:0]      r_ram_en;
    logic [7:0]            r_ram_we;
    logic [7:0]            r_ram_wstrb;
    logic [LANES*AW-1:0]   r_ram_addr;
    logic [LANES*DW-1:0]   r_ram_wdata;
    logic                  r_rsp_valid;
    logic [LANES-1:0]      r_rsp_mask;
    logic [LANES*DW-1:0]   r_rsp_rdata;
    logic [1:0]            r_rsp_error;
    logic [CW-1:0]         r_cnt;
    logic                  w_misalign;
    logic                  w_expire;

    always_comb begin
        w_misalign = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (req_mask[i] && (req_addr[i*AW +: 3] != 3'b000)) begin
                w_misalign = 1'b1;
            end
        end
    end

    assign w_expire = (TIMEOUT != 0) && (r_cnt == LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_ram_en    <= '0;
            r_ram_we    <= '0;
            r_ram_wstrb <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_mask  <= '0;
            r_rsp_rdata <= '0;
            r_rsp_error <= '0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_req_ready && req_valid) begin
                        r_req_ready <= 1'b0;
                        r_ram_addr  <= req_addr;
                        r_ram_wdata <= req_wdata;
                        r_rsp_mask  <= req_mask;
                        r_rsp_rdata <= '0;
                        r_rsp_error <= 2'd0;
                        if (req_mask == '0) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                        end else if (w_misalign) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 2'd1;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_ram_en    <= req_mask;
                            r_ram_we    <= {8{req_we}};
                            r_ram_wstrb <= req_we ? req_wstrb : 8'h00;
                            r_cnt       <= '0;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // ram_done takes priority over a coincident timeout
                    if (ram_done || w_expire) begin
                        r_state     <= S_RESP;
                        r_ram_en    <= '0;
                        r_ram_we    <= '0;
                        r_ram_wstrb <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= ram_done ? 2'd0 : 2'd2;
                        if (ram_done && !r_ram_we[0]) begin
                            for (int i = 0; i < LANES; i++) begin
                                r_rsp_rdata[i*DW +: DW] <= r_rsp_mask[i] ?
                                    ram_rdata[i*DW +: DW] : '0;
                            end
                        end
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_wstrb = r_ram_wstrb;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_mask  = r_rsp_mask;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_simd_mem_initiator.sv
// Directed bench for simd_mem_initiator: store, load, misalign, empty mask,
// timeout, backpressure, done/timeout tie and mid-transaction reset.
module tb_simd_mem_initiator;

    localparam int LANES = 32;
    localparam int AW    = 32;
    localparam int DW    = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [LANES-1:0]    req_mask;
    logic [7:0]          req_wstrb;
    logic [LANES*AW-1:0] req_addr;
    logic [LANES*DW-1:0] req_wdata;
    logic [LANES-1:0]    ram_en;
    logic [7:0]          ram_we;
    logic [7:0]          ram_wstrb;
    logic [LANES*AW-1:0] ram_addr;
    logic [LANES*DW-1:0] ram_wdata;
    logic [LANES*DW-1:0] ram_rdata;
    logic                ram_done;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [LANES-1:0]    rsp_mask;
    logic [LANES*DW-1:0] rsp_rdata;
    logic [1:0]          rsp_error;

    logic [LANES*AW-1:0] addr_v;
    logic [LANES*DW-1:0] data_v;

    int n_vec = 0;
    int n_err = 0;

    simd_mem_initiator #(
        .LANES(LANES), .AW(AW), .DW(DW), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_mask(req_mask),
        .req_wstrb(req_wstrb), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .ram_en(ram_en), .ram_we(ram_we),
        .ram_wstrb(ram_wstrb), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_done(ram_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_mask(rsp_mask), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // lane i expected: base+i when active, 0 otherwise
    task automatic chk_lanes(input string tag, input logic [LANES-1:0] m,
                             input int base);
        for (int i = 0; i < LANES; i++) begin
            chk($sformatf("%s[%0d]", tag, i), rsp_rdata[i*DW +: DW],
                m[i] ? 64'(base + i) : 64'd0);
        end
    endtask

    task automatic set_rdata(input int base);
        for (int i = 0; i < LANES; i++) ram_rdata[i*DW +: DW] = 64'(base + i);
    endtask

    initial begin
        for (int i = 0; i < LANES; i++) begin
            addr_v[i*AW +: AW] = AW'(i * 8);
            data_v[i*DW +: DW] = DW'(i);
        end
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mask = '0;
        req_wstrb = '0; req_addr = '0; req_wdata = '0; ram_rdata = '0;
        ram_done = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_rsp_mask", rsp_mask, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", req_ready, 1);

        // store, all lanes
        req_valid = 1'b1; req_we = 1'b1; req_mask = '1; req_wstrb = 8'hFF;
        req_addr = addr_v; req_wdata = data_v;
        tick();
        chk("st_req_ready", req_ready, 0);
        chk("st_ram_en", ram_en, 32'hFFFF_FFFF);
        chk("st_ram_we", ram_we, 8'hFF);
        chk("st_ram_wstrb", ram_wstrb, 8'hFF);
        req_valid = 1'b0; req_addr = ~addr_v; req_wdata = ~data_v;
        req_wstrb = 8'h0F;
        tick(); tick();
        chk("st_addr_held", 64'(ram_addr === addr_v), 1);
        chk("st_wdata_held", 64'(ram_wdata === data_v), 1);
        chk("st_en_held", ram_en, 32'hFFFF_FFFF);
        chk("st_wstrb_held", ram_wstrb, 8'hFF);
        chk("st_no_rsp", rsp_valid, 0);
        ram_done = 1'b1;
        tick();
        ram_done = 1'b0;
        chk("st_rsp_valid", rsp_valid, 1);
        chk("st_rsp_error", rsp_error, 0);
        chk("st_rsp_mask", rsp_mask, 32'hFFFF_FFFF);
        chk("st_en_drop", ram_en, 0);
        chk("st_we_drop", ram_we, 0);
        chk("st_rdata_zero", 64'(rsp_rdata === '0), 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("st_rsp_done", rsp_valid, 0);
        chk("st_ready_back", req_ready, 1);

        // load, minimum latency: done in the first ISSUE cycle
        req_valid = 1'b1; req_we = 1'b0; req_mask = '1;
        req_addr = addr_v; req_wstrb = 8'hFF;
        tick();
        req_valid = 1'b0;
        chk("ld_ram_en", ram_en, 32'hFFFF_FFFF);
        chk("ld_ram_we", ram_we, 0);
        chk("ld_ram_wstrb", ram_wstrb, 0);
        ram_done = 1'b1; set_rdata(0);
        tick();
        ram_done = 1'b0;
        chk("ld_rsp_valid", rsp_valid, 1);
        chk("ld_en_drop", ram_en, 0);
        chk_lanes("ld_rdata", '1, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // partial-mask load; done held high into RESP must be ignored
        req_valid = 1'b1; req_mask = 32'h0000_00F0;
        tick();
        req_valid = 1'b0;
        chk("pm_ram_en", ram_en, 32'h0000_00F0);
        ram_done = 1'b1; set_rdata(100);
        tick();
        set_rdata(500);
        tick();
        ram_done = 1'b0;
        chk("pm_rsp_valid", rsp_valid, 1);
        chk("pm_rsp_mask", rsp_mask, 32'h0000_00F0);
        chk_lanes("pm_rdata", 32'h0000_00F0, 100);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // misaligned active lane
        req_valid = 1'b1; req_mask = 32'h0000_0001;
        req_addr = addr_v; req_addr[2:0] = 3'h4;
        tick();
        req_valid = 1'b0;
        chk("mis_ram_en", ram_en, 0);
        chk("mis_rsp_valid", rsp_valid, 1);
        chk("mis_rsp_error", rsp_error, 1);
        chk("mis_req_ready", req_ready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // empty mask
        req_valid = 1'b1; req_mask = '0;
        tick();
        req_valid = 1'b0;
        chk("m0_ram_en", ram_en, 0);
        chk("m0_rsp_valid", rsp_valid, 1);
        chk("m0_rsp_error", rsp_error, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // misaligned inactive lane is not an error
        req_valid = 1'b1; req_mask = 32'h0000_0001;
        req_addr = addr_v; req_addr[AW +: 3] = 3'h4;
        tick();
        req_valid = 1'b0;
        chk("mi_ram_en", ram_en, 1);
        ram_done = 1'b1;
        tick();
        ram_done = 1'b0;
        chk("mi_rsp_error", rsp_error, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // timeout: no done for 16 ISSUE cycles
        req_valid = 1'b1; req_mask = '1; req_addr = addr_v;
        tick();
        req_valid = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            tick();
            chk($sformatf("to_en_c%0d", k), ram_en, 32'hFFFF_FFFF);
        end
        chk("to_no_rsp_c16", rsp_valid, 0);
        tick();
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_error", rsp_error, 2);
        chk("to_en_drop", ram_en, 0);
        chk("to_rdata_zero", 64'(rsp_rdata === '0), 1);

        // backpressure with a new request already waiting
        req_valid = 1'b1; req_mask = 32'h0000_000F; set_rdata(7);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp_valid_%0d", k), rsp_valid, 1);
            chk($sformatf("bp_error_%0d", k), rsp_error, 2);
            chk($sformatf("bp_ready_%0d", k), req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_rsp_done", rsp_valid, 0);
        chk("bp_not_yet", ram_en, 0);
        chk("bp_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("bp_accept_en", ram_en, 32'h0000_000F);

        // done coincides with the timeout cycle: done wins
        for (int k = 2; k <= 16; k++) tick();
        ram_done = 1'b1;
        tick();
        ram_done = 1'b0;
        chk("tie_rsp_valid", rsp_valid, 1);
        chk("tie_rsp_error", rsp_error, 0);
        chk_lanes("tie_rdata", 32'h0000_000F, 7);

        // reset during ISSUE
        rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_mask = '1;
        tick();
        rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("rr_in_issue", ram_en, 32'hFFFF_FFFF);
        reset = 1'b1;
        #1;
        chk("rr_en_now", ram_en, 0);
        chk("rr_we_now", ram_we, 0);
        chk("rr_valid_now", rsp_valid, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("rr_req_ready", req_ready, 1);
        chk("rr_no_rsp", rsp_valid, 0);
        chk("rr_en_idle", ram_en, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
